// File: rtl/load_store_align_if.sv
// load_store_align_if: pipeline and data-memory signals of the load/store aligner
// Ports (grouped):
//   request : i_mem_read, i_mem_write, i_funct3, i_address, i_store_data
//   pipeline: o_load_data, o_stall, o_misaligned, o_bad_addr
//   memory  : o_dm_read, o_dm_write, o_dm_address, o_dm_write_data, i_dm_read_data
//   master drives requests and memory read data; slave is the aligner
interface load_store_align_if #(parameter int ADDR_WIDTH = 32);
  logic i_mem_read;
  logic i_mem_write;
  logic [2:0] i_funct3;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [31:0] i_store_data;
  logic [31:0] o_load_data;
  logic o_stall;
  logic o_misaligned;
  logic [ADDR_WIDTH-1:0] o_bad_addr;
  logic o_dm_read;
  logic o_dm_write;
  logic [ADDR_WIDTH-1:0] o_dm_address;
  logic [31:0] o_dm_write_data;
  logic [31:0] i_dm_read_data;
  modport master (
    output i_mem_read, i_mem_write, i_funct3, i_address, i_store_data, i_dm_read_data,
    input o_load_data, o_stall, o_misaligned, o_bad_addr, o_dm_read, o_dm_write, o_dm_address, o_dm_write_data
  );
  modport slave (
    input i_mem_read, i_mem_write, i_funct3, i_address, i_store_data, i_dm_read_data,
    output o_load_data, o_stall, o_misaligned, o_bad_addr, o_dm_read, o_dm_write, o_dm_address, o_dm_write_data
  );
endinterface

// File: rtl/load_store_align.sv
// load_store_align: RV32I load/store to word-memory aligner with 2-cycle RMW for SB/SH
// Ports: i_clk, i_rst_n (async active-low), bus (load_store_align_if.slave)
// Optional: LSU_MISALIGN_TRAP_EN flags misaligned H/W accesses instead of aligning down
module load_store_align #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BAD_ADDR_RST = '0
) (
  input logic i_clk,
  input logic i_rst_n,
  load_store_align_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;
  logic [0:0] st_q;
  logic [31:0] merge_q, merge, rd, sd, shifted, ext;
  logic [ADDR_WIDTH-1:0] addr_q, aligned;
  logic [2:0] f3;
  logic [1:0] lane;
  logic [4:0] bsh, hsh;
  logic [7:0] b;
  logic [15:0] h;
  logic legal, mis, idle, rmw, req, go, ld, sw, sub;
  assign f3 = bus.i_funct3;
  assign lane = bus.i_address[1:0];
  assign rd = bus.i_dm_read_data;
  assign sd = bus.i_store_data;
  assign aligned = {bus.i_address[ADDR_WIDTH-1:2], 2'b00};
  assign legal = ~(f3[1] & (f3[0] | f3[2]));
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (f3[1:0] == 2'b01 & lane[0]) | (f3[1] & lane != 2'b00);
`else
  assign mis = 1'b0;
`endif
  // reset gates every request-derived output, so nothing leaks while i_rst_n is low
  assign idle = i_rst_n & (st_q == IDLE);
  assign rmw = i_rst_n & (st_q == RMW_WR);
  assign req = bus.i_mem_read | bus.i_mem_write;
  assign go = idle & req & legal & ~mis;
  assign ld = go & ~bus.i_mem_write;
  assign sw = go & bus.i_mem_write & f3[1];
  assign sub = go & bus.i_mem_write & ~f3[1];
  assign bsh = {lane, 3'b000};
  assign hsh = {lane[1], 4'b0000};
  assign shifted = rd >> bsh;
  assign b = shifted[7:0];
  assign h = lane[1] ? rd[31:16] : rd[15:0];
  // f3[2] selects zero extension for BU/HU
  assign ext = f3[1] ? rd : f3[0] ? {{16{h[15] & ~f3[2]}}, h} : {{24{b[7] & ~f3[2]}}, b};
  assign merge = f3[0] ? (rd & ~(32'hFFFF << hsh)) | ({16'h0, sd[15:0]} << hsh)
                       : (rd & ~(32'hFF << bsh)) | ({24'h0, sd[7:0]} << bsh);
  assign bus.o_dm_read = ld | sub;
  assign bus.o_dm_write = sw | rmw;
  assign bus.o_stall = sub;
  assign bus.o_dm_address = rmw ? addr_q : go ? aligned : '0;
  assign bus.o_dm_write_data = rmw ? merge_q : sw ? sd : '0;
  assign bus.o_load_data = ld ? ext : '0;
  assign bus.o_misaligned = idle & req & legal & mis;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      st_q <= IDLE;
      merge_q <= '0;
      addr_q <= '0;
    end else begin
      st_q <= sub ? RMW_WR : IDLE;
      if (sub) begin
        merge_q <= merge;
        addr_q <= aligned;
      end
    end
`ifdef LSU_MISALIGN_TRAP_EN
  logic [ADDR_WIDTH-1:0] bad_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) bad_q <= BAD_ADDR_RST;
    else if (bus.o_misaligned) bad_q <= bus.i_address;
  assign bus.o_bad_addr = bad_q;
`else
  assign bus.o_bad_addr = BAD_ADDR_RST;
`endif
endmodule

// File: tb/tb_load_store_align.sv
// tb_load_store_align: directed vector table plus RMW/reset/misalign sequences
module tb_load_store_align;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  load_store_align_if #(.ADDR_WIDTH(32)) bus();
  load_store_align #(.ADDR_WIDTH(32), .BAD_ADDR_RST(32'h0)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  logic [31:0] mem [0:63];
  logic pl_en = 1'b0;
  logic [5:0] pl_idx = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk)
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.o_dm_write) mem[bus.o_dm_address[7:2]] <= bus.o_dm_write_data;
  assign bus.i_dm_read_data = mem[bus.o_dm_address[7:2]];
  int total = 0;
  int passed = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  task automatic ap(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd);
    @(negedge clk);
    bus.i_mem_read = mr;
    bus.i_mem_write = mw;
    bus.i_funct3 = f3;
    bus.i_address = addr;
    bus.i_store_data = sd;
    #1;
  endtask
  typedef struct {
    string n;
    logic mr, mw;
    logic [2:0] f3;
    logic [31:0] addr, sd, ld;
    logic stall, dmr, dmw;
  } vec_t;
  vec_t v [11];
  initial begin
    v[0]  = '{"lb_41",    1, 0, 3'b000, 32'h41, 32'h0,    32'hFFFFFFAA, 0, 1, 0};
    v[1]  = '{"lbu_41",   1, 0, 3'b100, 32'h41, 32'h0,    32'h000000AA, 0, 1, 0};
    v[2]  = '{"lh_42",    1, 0, 3'b001, 32'h42, 32'h0,    32'hFFFF8899, 0, 1, 0};
    v[3]  = '{"lhu_40",   1, 0, 3'b101, 32'h40, 32'h0,    32'h0000AABB, 0, 1, 0};
    v[4]  = '{"lw_40",    1, 0, 3'b010, 32'h40, 32'h0,    32'h8899AABB, 0, 1, 0};
    v[5]  = '{"lb_43",    1, 0, 3'b000, 32'h43, 32'h0,    32'hFFFFFF88, 0, 1, 0};
    v[6]  = '{"lhu_42",   1, 0, 3'b101, 32'h42, 32'h0,    32'h00008899, 0, 1, 0};
    v[7]  = '{"ill011_r", 1, 0, 3'b011, 32'h40, 32'h0,    32'h0,        0, 0, 0};
    v[8]  = '{"ill111_w", 0, 1, 3'b111, 32'h40, 32'h5,    32'h0,        0, 0, 0};
    v[9]  = '{"noreq",    0, 0, 3'b000, 32'h40, 32'h0,    32'h0,        0, 0, 0};
    v[10] = '{"rd_wr_sw", 1, 1, 3'b010, 32'h48, 32'h1234, 32'h0,        0, 0, 1};
    bus.i_mem_read = 1'b1;
    bus.i_mem_write = 1'b0;
    bus.i_funct3 = 3'b000;
    bus.i_address = 32'h41;
    bus.i_store_data = 32'h0;
    pl_en = 1'b1;
    pl_idx = 6'd16;
    pl_data = 32'h8899AABB;
    #1;
    chk("rst_stall", {31'h0, bus.o_stall}, 32'h0);
    chk("rst_dmr", {31'h0, bus.o_dm_read}, 32'h0);
    chk("rst_dmw", {31'h0, bus.o_dm_write}, 32'h0);
    chk("rst_ld", bus.o_load_data, 32'h0);
    chk("rst_mis", {31'h0, bus.o_misaligned}, 32'h0);
    chk("rst_bad", bus.o_bad_addr, 32'h0);
    @(negedge clk);
    pl_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      ap(v[i].mr, v[i].mw, v[i].f3, v[i].addr, v[i].sd);
      chk({v[i].n, "_ld"}, bus.o_load_data, v[i].ld);
      chk({v[i].n, "_stall"}, {31'h0, bus.o_stall}, {31'h0, v[i].stall});
      chk({v[i].n, "_dmr"}, {31'h0, bus.o_dm_read}, {31'h0, v[i].dmr});
      chk({v[i].n, "_dmw"}, {31'h0, bus.o_dm_write}, {31'h0, v[i].dmw});
    end
    ap(1, 0, 3'b010, 32'h4A, 32'h0);
    chk("lw_48_after_sw", bus.o_load_data, 32'h00001234);
    ap(0, 1, 3'b000, 32'h43, 32'h12);
    chk("sb_c0_stall", {31'h0, bus.o_stall}, 32'h1);
    chk("sb_c0_dmr", {31'h0, bus.o_dm_read}, 32'h1);
    chk("sb_c0_dmw", {31'h0, bus.o_dm_write}, 32'h0);
    @(negedge clk);
    #1;
    chk("sb_c1_dmw", {31'h0, bus.o_dm_write}, 32'h1);
    chk("sb_c1_wdata", bus.o_dm_write_data, 32'h1299AABB);
    chk("sb_c1_addr", bus.o_dm_address, 32'h40);
    chk("sb_c1_stall", {31'h0, bus.o_stall}, 32'h0);
    chk("sb_c1_dmr", {31'h0, bus.o_dm_read}, 32'h0);
    ap(0, 0, 3'b000, 32'h0, 32'h0);
    chk("sb_c2_dmw", {31'h0, bus.o_dm_write}, 32'h0);
    chk("sb_mem", mem[16], 32'h1299AABB);
    pl_en = 1'b1;
    pl_data = 32'h8899AABB;
    @(negedge clk);
    pl_en = 1'b0;
    ap(0, 1, 3'b001, 32'h40, 32'hCAFE);
    chk("sh_c0_stall", {31'h0, bus.o_stall}, 32'h1);
    @(negedge clk);
    #1;
    chk("sh_c1_wdata", bus.o_dm_write_data, 32'h8899CAFE);
    ap(0, 1, 3'b010, 32'h44, 32'hDEADBEEF);
    chk("sw_b2b_stall", {31'h0, bus.o_stall}, 32'h0);
    chk("sw_b2b_dmw", {31'h0, bus.o_dm_write}, 32'h1);
    chk("sw_b2b_wdata", bus.o_dm_write_data, 32'hDEADBEEF);
    chk("sw_b2b_addr", bus.o_dm_address, 32'h44);
    ap(0, 0, 3'b000, 32'h0, 32'h0);
    chk("sh_mem", mem[16], 32'h8899CAFE);
    chk("sw_mem", mem[17], 32'hDEADBEEF);
    ap(1, 0, 3'b010, 32'h42, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_flag", {31'h0, bus.o_misaligned}, 32'h1);
    chk("mis_dmr", {31'h0, bus.o_dm_read}, 32'h0);
    chk("mis_ld", bus.o_load_data, 32'h0);
    ap(0, 0, 3'b000, 32'h0, 32'h0);
    chk("mis_bad", bus.o_bad_addr, 32'h42);
`else
    chk("mis_flag", {31'h0, bus.o_misaligned}, 32'h0);
    chk("mis_dmr", {31'h0, bus.o_dm_read}, 32'h1);
    chk("mis_ld", bus.o_load_data, 32'h8899CAFE);
    chk("mis_addr", bus.o_dm_address, 32'h40);
    ap(0, 0, 3'b000, 32'h0, 32'h0);
    chk("mis_bad", bus.o_bad_addr, 32'h0);
`endif
    ap(0, 1, 3'b000, 32'h41, 32'h77);
    chk("rrst_c0_stall", {31'h0, bus.o_stall}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rrst_dmw", {31'h0, bus.o_dm_write}, 32'h0);
    chk("rrst_stall", {31'h0, bus.o_stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_mem_read = 1'b1;
    bus.i_mem_write = 1'b0;
    bus.i_funct3 = 3'b100;
    bus.i_address = 32'h40;
    #1;
    chk("rrst_idle_dmw", {31'h0, bus.o_dm_write}, 32'h0);
    chk("rrst_idle_stall", {31'h0, bus.o_stall}, 32'h0);
    chk("rrst_idle_ld", bus.o_load_data, 32'h000000FE);
    chk("rrst_mem", mem[16], 32'h8899CAFE);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
